// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - start/busy/done handshake bundle for mult_seq; sign_mode exists only under MULT_SEQ_SIGNED_EN
interface mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start_p;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef MULT_SEQ_SIGNED_EN
  logic                 sign_mode;
`endif
  logic                 busy;
  logic                 done_p;
  logic [2*WIDTH-1:0]   o;

`ifdef MULT_SEQ_SIGNED_EN
  modport master (output start_p, a, b, sign_mode, input busy, done_p, o);
  modport slave  (input start_p, a, b, sign_mode, output busy, done_p, o);
`else
  modport master (output start_p, a, b, input busy, done_p, o);
  modport slave  (input start_p, a, b, output busy, done_p, o);
`endif
endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - iterative shift-add multiplier retiring BPC bits per cycle; MULT_SEQ_SIGNED_EN adds sign_mode
module mult_seq #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  mult_seq_if.slave  bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
    $error("mult_seq: WIDTH must be >= 2 and a multiple of BPC");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    o_q;

  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [PW-1:0]    term_d;
  logic [PW-1:0]    sum_d;
  logic [PW-1:0]    final_d;
  logic             last_d;

`ifdef MULT_SEQ_SIGNED_EN
  logic             neg_q;
  logic             neg_d;
`endif

  // Operand capture: in signed mode the datapath only ever sees magnitudes;
  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag_d = bus.a;
    b_mag_d = bus.b;
`ifdef MULT_SEQ_SIGNED_EN
    neg_d = bus.sign_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    if (bus.sign_mode && bus.a[WIDTH-1]) a_mag_d = -bus.a;
    if (bus.sign_mode && bus.b[WIDTH-1]) b_mag_d = -bus.b;
`endif
  end

  // One iteration: add the pre-shifted multiplicand for each of the low BPC multiplier bits.
  always_comb begin
    term_d = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_q[i]) term_d = term_d + (mcand_q << i);
    end
    sum_d   = acc_q + term_d;
    final_d = sum_d;
`ifdef MULT_SEQ_SIGNED_EN
    if (neg_q) final_d = -sum_d;
`endif
    last_d  = (cnt_q == CW'(N - 1));
  end

  // Control FSM and datapath registers; outputs are registered so done_p and o change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      o_q      <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_p) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
            mplier_q <= b_mag_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef MULT_SEQ_SIGNED_EN
            neg_q    <= neg_d;
`endif
          end
        end
        RUN: begin
          acc_q    <= sum_d;
          mcand_q  <= mcand_q << BPC;
          mplier_q <= mplier_q >> BPC;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            o_q     <= final_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done_p = done_q;
  assign bus.o      = o_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - scoreboard bench for mult_seq (BPC=1 and BPC=2 instances); signed cases under MULT_SEQ_SIGNED_EN
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef MULT_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        st[2];
  logic [7:0]  av[2];
  logic [7:0]  bv[2];
  logic        sm[2];
  logic        busy_w[2];
  logic        done_w[2];
  logic [15:0] o_w[2];

  mult_seq_if #(.WIDTH(8)) bus0 ();
  mult_seq_if #(.WIDTH(8)) bus1 ();

  assign bus0.start_p = st[0];
  assign bus0.a       = av[0];
  assign bus0.b       = bv[0];
  assign bus1.start_p = st[1];
  assign bus1.a       = av[1];
  assign bus1.b       = bv[1];
`ifdef MULT_SEQ_SIGNED_EN
  assign bus0.sign_mode = sm[0];
  assign bus1.sign_mode = sm[1];
`endif
  assign busy_w[0] = bus0.busy;
  assign done_w[0] = bus0.done_p;
  assign o_w[0]    = bus0.o;
  assign busy_w[1] = bus1.busy;
  assign done_w[1] = bus1.done_p;
  assign o_w[1]    = bus1.o;

  mult_seq #(.WIDTH(8), .BPC(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mult_seq #(.WIDTH(8), .BPC(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [15:0] o;
    int          cyc;
  } exp_t;

  exp_t        sbq[2][$];
  exp_t        mon_e;
  exp_t        new_e;
  int          ncyc = 0;
  int          free_at[2];
  int          acc_k[2];
  logic [15:0] hold[2];
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic int n_of(int d);
    return (d == 0) ? 8 : 4;
  endfunction

  // Reference: plain integer product, truncated to the 16-bit result.
  function automatic logic [15:0] ref_prod(logic [7:0] x, logic [7:0] y, logic s);
    int xi;
    int yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  task automatic chk(int d, string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s at cycle %0d: got %0h, expected %0h", d, nm, ncyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives one start pulse; the model decides acceptance from its own busy bookkeeping.
  task automatic issue(int d, logic [7:0] x, logic [7:0] y, logic s_in);
    logic s;
    s = s_in & SIGNED_EN;
    st[d] = 1'b1;
    av[d] = x;
    bv[d] = y;
    sm[d] = s;
    if (ncyc >= free_at[d]) begin
      new_e.o   = ref_prod(x, y, s);
      new_e.cyc = ncyc + n_of(d) + 1;
      sbq[d].push_back(new_e);
      acc_k[d]   = ncyc;
      free_at[d] = ncyc + n_of(d) + 1;
    end
    tick();
    st[d] = 1'b0;
    av[d] = 8'($urandom);
    bv[d] = 8'($urandom);
    sm[d] = 1'($urandom);
  endtask

  task automatic wait_free(int d);
    int guard;
    guard = 0;
    while (ncyc < free_at[d] && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL dut%0d wait_free timeout at cycle %0d", d, ncyc);
    end
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sbq[d].delete();
      free_at[d] = ncyc + 1;
      hold[d]    = '0;
    end
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Monitor: every cycle, each DUT either completes the oldest expected job or holds its result.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (sbq[d].size() > 0 && sbq[d][0].cyc == ncyc) begin
          mon_e = sbq[d].pop_front();
          chk(d, "done_p", 16'(done_w[d]), 16'd1);
          chk(d, "o", o_w[d], mon_e.o);
          hold[d] = mon_e.o;
        end else begin
          chk(d, "idle_done_p", 16'(done_w[d]), 16'd0);
          chk(d, "o_hold", o_w[d], hold[d]);
        end
        chk(d, "busy", 16'(busy_w[d]), 16'(ncyc > acc_k[d] && ncyc < free_at[d]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; av[d] = '0; bv[d] = '0; sm[d] = 1'b0;
      free_at[d] = 0; acc_k[d] = -1; hold[d] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    issue(0, 8'd255, 8'd255, 1'b0);
    wait_free(0);
    issue(0, 8'd0, 8'd200, 1'b0);
    wait_free(0);
    issue(0, 8'd12, 8'd13, 1'b0);
    wait_free(0);

    issue(0, 8'd7, 8'd9, 1'b0);
    tick();
    tick();
    issue(0, 8'd1, 8'd1, 1'b0);
    wait_free(0);

    issue(0, 8'd100, 8'd100, 1'b0);
    tick();
    tick();
    tick();
    do_reset(1);
    issue(0, 8'd3, 8'd4, 1'b0);
    wait_free(0);

    issue(1, 8'd200, 8'd150, 1'b0);
    wait_free(1);

`ifdef MULT_SEQ_SIGNED_EN
    issue(0, 8'h80, 8'h80, 1'b1);
    wait_free(0);
    issue(0, 8'hFD, 8'd5, 1'b1);
    wait_free(0);
    issue(0, 8'd127, 8'hFF, 1'b1);
    wait_free(0);
    issue(0, 8'hFD, 8'd5, 1'b0);
    wait_free(0);
    issue(1, 8'h80, 8'h7F, 1'b1);
    wait_free(1);
`endif

    for (int it = 0; it < 300; it++) begin
      issue(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 9)) tick();
      if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(1, 2)));
    end

    wait_free(0);
    wait_free(1);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) chk(d, "scoreboard_drained", 16'(sbq[d].size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
